// File: rtl/mem_responder.sv
// Memory-bus responder: decodes RAM, one I/O port, the reset vector and unmapped space.
// Latency: ready is high WAIT_STATES+1 cycles after the cycle in which req is accepted.
// Backpressure: one access outstanding; req is ignored while busy and re-sampled in IDLE.
module mem_responder #(
  parameter int          RAM_AW      = 10,
  parameter int          WAIT_STATES = 1,
  parameter logic [15:0] IO_ADDR     = 16'hD000,
  parameter logic [15:0] RESET_VEC   = 16'h0200
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       req,
  input  logic       rw,
  input  logic [7:0] abh,
  input  logic [7:0] abl,
  input  logic [7:0] wdata,
  output logic [7:0] rdata,
  output logic       ready,
  output logic       err,
  output logic       busy,
  output logic [7:0] io_port
);

  localparam int          RAM_DEPTH = 1 << RAM_AW;
  localparam logic [16:0] RAM_LIMIT = 17'(RAM_DEPTH);
  localparam logic [3:0]  WS        = 4'(WAIT_STATES);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] addr_q, addr_d;
  logic        rw_q, rw_d;
  logic [7:0]  wdata_q, wdata_d;
  logic [7:0]  rdata_q, rdata_d;
  logic        ready_q, ready_d;
  logic        err_q, err_d;
  logic        busy_q, busy_d;
  logic [7:0]  io_port_q, io_port_d;
  logic        ram_we;

  logic [7:0]  mem [RAM_DEPTH];

  // Decode of the address about to be answered (drives the registered response).
  logic d_io, d_ram, d_vlo, d_vhi;
  // Decode of the address currently in RESP (drives the write commit).
  logic q_io, q_ram;

  assign d_io  = (addr_d == IO_ADDR);
  assign d_ram = ({1'b0, addr_d} < RAM_LIMIT) && !d_io;
  assign d_vlo = (addr_d == 16'hFFFC);
  assign d_vhi = (addr_d == 16'hFFFD);
  assign q_io  = (addr_q == IO_ADDR);
  assign q_ram = ({1'b0, addr_q} < RAM_LIMIT) && !q_io;

  // Next-state, latching, write commit and registered response computed ahead of RESP.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    rw_d      = rw_q;
    wdata_d   = wdata_q;
    io_port_d = io_port_q;
    ram_we    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          addr_d  = {abh, abl};
          rw_d    = rw;
          wdata_d = wdata;
          if (WS == 4'd0) begin
            state_d = S_RESP;
          end else begin
            state_d = S_WAIT;
            cnt_d   = WS;
          end
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = S_RESP;
      end
      S_RESP: begin
        state_d = S_IDLE;
        // Writes land on the edge that leaves RESP, so a reset before then discards them.
        if (!rw_q) begin
          if (q_io)       io_port_d = wdata_q;
          else if (q_ram) ram_we    = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    ready_d = (state_d == S_RESP);
    busy_d  = (state_d != S_IDLE);
    rdata_d = 8'h00;
    err_d   = 1'b0;
    if (state_d == S_RESP) begin
      if (d_io) begin
        if (rw_d) rdata_d = io_port_q;
      end else if (d_ram) begin
        if (rw_d) rdata_d = mem[addr_d[RAM_AW-1:0]];
      end else if (d_vlo) begin
        if (rw_d) rdata_d = RESET_VEC[7:0];
        else      err_d   = 1'b1;
      end else if (d_vhi) begin
        if (rw_d) rdata_d = RESET_VEC[15:8];
        else      err_d   = 1'b1;
      end else begin
        err_d = 1'b1;
        if (rw_d) rdata_d = 8'hFF;
      end
    end
  end

  // FSM and output registers; reset aborts any access in flight.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q   <= S_IDLE;
      cnt_q     <= 4'd0;
      addr_q    <= 16'h0000;
      rw_q      <= 1'b1;
      wdata_q   <= 8'h00;
      rdata_q   <= 8'h00;
      ready_q   <= 1'b0;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
      io_port_q <= 8'h00;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      rw_q      <= rw_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      ready_q   <= ready_d;
      err_q     <= err_d;
      busy_q    <= busy_d;
      io_port_q <= io_port_d;
    end
  end

  // RAM array write port; contents survive reset.
  always_ff @(posedge clk) begin
    if (ram_we) mem[addr_q[RAM_AW-1:0]] <= wdata_q;
  end

  assign rdata   = rdata_q;
  assign ready   = ready_q;
  assign err     = err_q;
  assign busy    = busy_q;
  assign io_port = io_port_q;

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: instance 0 has one wait state, instance 1 has none.
module tb_mem_responder;

  logic       clk;
  logic       clr;
  logic       req_s [2];
  logic       rw_s  [2];
  logic [7:0] abh_s [2];
  logic [7:0] abl_s [2];
  logic [7:0] wd_s  [2];
  logic [7:0] rdata_o [2];
  logic       ready_o [2];
  logic       err_o   [2];
  logic       busy_o  [2];
  logic [7:0] io_o    [2];

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  mem_responder #(.WAIT_STATES(1)) u0 (
    .clk(clk), .clr(clr), .req(req_s[0]), .rw(rw_s[0]), .abh(abh_s[0]), .abl(abl_s[0]),
    .wdata(wd_s[0]), .rdata(rdata_o[0]), .ready(ready_o[0]), .err(err_o[0]),
    .busy(busy_o[0]), .io_port(io_o[0]));

  mem_responder #(.WAIT_STATES(0)) u1 (
    .clk(clk), .clr(clr), .req(req_s[1]), .rw(rw_s[1]), .abh(abh_s[1]), .abl(abl_s[1]),
    .wdata(wd_s[1]), .rdata(rdata_o[1]), .ready(ready_o[1]), .err(err_o[1]),
    .busy(busy_o[1]), .io_port(io_o[1]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  logic [7:0]  mem_m   [2][1024];
  bit          known_m [2][1024];
  logic [7:0]  io_m    [2];
  int          acc_c   [2];
  int          rsp_c   [2];
  bit          pend_ram[2];
  bit          pend_io [2];
  logic [15:0] pa_m    [2];
  logic [7:0]  pd_m    [2];
  logic [7:0]  rd_m    [2];
  bit          rdv_m   [2];
  bit          e_m     [2];

  function automatic int ws_of(input int k);
    return (k == 0) ? 1 : 0;
  endfunction

  initial begin
    for (int k = 0; k < 2; k++) begin
      io_m[k] = 8'h00; acc_c[k] = -10; rsp_c[k] = -10;
      pend_ram[k] = 0; pend_io[k] = 0; rd_m[k] = 8'h00; rdv_m[k] = 0; e_m[k] = 0;
    end
  end

  always @(posedge clk) begin
    logic [15:0] a;
    cyc = cyc + 1;
    for (int k = 0; k < 2; k++) begin
      if (clr) begin
        io_m[k] = 8'h00; acc_c[k] = -10; rsp_c[k] = -10;
        pend_ram[k] = 0; pend_io[k] = 0;
      end else begin
        if (cyc == rsp_c[k] + 1) begin
          if (pend_ram[k]) begin
            mem_m[k][pa_m[k][9:0]] = pd_m[k];
            known_m[k][pa_m[k][9:0]] = 1;
          end
          if (pend_io[k]) io_m[k] = pd_m[k];
          pend_ram[k] = 0; pend_io[k] = 0;
        end
        if (req_s[k] === 1'b1 && cyc >= rsp_c[k] + 2) begin
          a = {abh_s[k], abl_s[k]};
          acc_c[k] = cyc;
          rsp_c[k] = cyc + ws_of(k);
          pa_m[k] = a; pd_m[k] = wd_s[k];
          rd_m[k] = 8'h00; rdv_m[k] = 0; e_m[k] = 0;
          if (a == 16'hD000) begin
            if (rw_s[k]) begin rd_m[k] = io_m[k]; rdv_m[k] = 1; end
            else pend_io[k] = 1;
          end else if (a < 16'h0400) begin
            if (rw_s[k]) begin rd_m[k] = mem_m[k][a[9:0]]; rdv_m[k] = known_m[k][a[9:0]]; end
            else pend_ram[k] = 1;
          end else if (a == 16'hFFFC || a == 16'hFFFD) begin
            if (rw_s[k]) begin rd_m[k] = (a == 16'hFFFC) ? 8'h00 : 8'h02; rdv_m[k] = 1; end
            else e_m[k] = 1;
          end else begin
            e_m[k] = 1;
            if (rw_s[k]) begin rd_m[k] = 8'hFF; rdv_m[k] = 1; end
          end
        end
      end
    end
  end

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Cycle-by-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    bit er;
    for (int k = 0; k < 2; k++) begin
      if (clr) begin
        chk("rst_ready", {7'd0, ready_o[k]}, 8'h00);
        chk("rst_busy",  {7'd0, busy_o[k]},  8'h00);
        chk("rst_err",   {7'd0, err_o[k]},   8'h00);
        chk("rst_rdata", rdata_o[k], 8'h00);
        chk("rst_io",    io_o[k],    8'h00);
      end else begin
        er = (cyc == rsp_c[k]);
        chk("ready", {7'd0, ready_o[k]}, {7'd0, er});
        chk("busy",  {7'd0, busy_o[k]},  {7'd0, (cyc >= acc_c[k] && cyc <= rsp_c[k])});
        chk("err",   {7'd0, err_o[k]},   {7'd0, er && e_m[k]});
        chk("io_port", io_o[k], io_m[k]);
        if (!er) chk("rdata_idle", rdata_o[k], 8'h00);
        else if (rdv_m[k]) chk("rdata", rdata_o[k], rd_m[k]);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic do_acc(input int k, input bit r, input logic [15:0] a, input logic [7:0] wd,
                        input bit drop, output logic [7:0] rd, output logic e,
                        output int lat, output int rc);
    bit got;
    @(posedge clk); #1;
    req_s[k] = 1'b1; rw_s[k] = r; abh_s[k] = a[15:8]; abl_s[k] = a[7:0]; wd_s[k] = wd;
    lat = 0; got = 0; rd = 8'h00; e = 1'b0; rc = 0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(posedge clk); lat++;
      @(negedge clk);
      if (ready_o[k] === 1'b1) got = 1;
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL timeout waiting for ready addr %h got none expected pulse", a);
    end else begin
      rd = rdata_o[k]; e = err_o[k]; rc = cyc;
    end
    if (drop) req_s[k] = 1'b0;
  endtask

  initial begin
    logic [7:0] rd;
    logic e;
    int lat, rc, rc1, rc2;
    bit saw;
    clr = 1'b1;
    for (int k = 0; k < 2; k++) begin
      req_s[k] = 0; rw_s[k] = 1; abh_s[k] = 0; abl_s[k] = 0; wd_s[k] = 0;
    end
    repeat (3) @(posedge clk);
    #1 clr = 1'b0;

    // 1: reset vector reads
    do_acc(0, 1, 16'hFFFC, 8'h00, 1, rd, e, lat, rc);
    chk("vec_lo", rd, 8'h00); chk("vec_lo_err", {7'd0, e}, 8'h00); chk("vec_lo_lat", 8'(lat), 8'd2);
    do_acc(0, 1, 16'hFFFD, 8'h00, 1, rd, e, lat, rc);
    chk("vec_hi", rd, 8'h02); chk("vec_hi_err", {7'd0, e}, 8'h00); chk("vec_hi_lat", 8'(lat), 8'd2);

    // 2: RAM write/read including top address
    do_acc(0, 0, 16'h0010, 8'hA5, 1, rd, e, lat, rc);
    chk("wr10_err", {7'd0, e}, 8'h00);
    do_acc(0, 1, 16'h0010, 8'h00, 1, rd, e, lat, rc);
    chk("ram10", rd, 8'hA5);
    do_acc(0, 0, 16'h03FF, 8'h3C, 1, rd, e, lat, rc);
    do_acc(0, 1, 16'h03FF, 8'h00, 1, rd, e, lat, rc);
    chk("ram3ff", rd, 8'h3C); chk("ram3ff_err", {7'd0, e}, 8'h00);

    // 3: unmapped and read-only accesses
    do_acc(0, 1, 16'h0400, 8'h00, 1, rd, e, lat, rc);
    chk("unmap_rd", rd, 8'hFF); chk("unmap_err", {7'd0, e}, 8'h01);
    do_acc(0, 0, 16'hFFFC, 8'h99, 1, rd, e, lat, rc);
    chk("vec_wr_err", {7'd0, e}, 8'h01);
    do_acc(0, 1, 16'hFFFC, 8'h00, 1, rd, e, lat, rc);
    chk("vec_after_wr", rd, 8'h00);

    // 4: I/O port
    do_acc(0, 0, 16'hD000, 8'h5A, 1, rd, e, lat, rc);
    chk("io_in_ready", io_o[0], 8'h00);
    @(negedge clk);
    chk("io_after", io_o[0], 8'h5A);
    do_acc(0, 1, 16'hD000, 8'h00, 1, rd, e, lat, rc);
    chk("io_rd", rd, 8'h5A);

    // 5: reset during WAIT aborts a write
    do_acc(0, 0, 16'h0020, 8'h00, 1, rd, e, lat, rc);
    @(posedge clk); #1;
    req_s[0] = 1; rw_s[0] = 0; abh_s[0] = 8'h00; abl_s[0] = 8'h20; wd_s[0] = 8'h77;
    @(posedge clk); #1;
    clr = 1'b1; req_s[0] = 0;
    @(negedge clk);
    chk("abort_busy", {7'd0, busy_o[0]}, 8'h00);
    chk("abort_io", io_o[0], 8'h00);
    repeat (2) @(posedge clk);
    #1 clr = 1'b0;
    saw = 0;
    repeat (4) begin @(negedge clk); if (ready_o[0] === 1'b1) saw = 1; end
    chk("abort_no_ready", {7'd0, saw}, 8'h00);
    do_acc(0, 1, 16'h0020, 8'h00, 1, rd, e, lat, rc);
    chk("abort_ram", rd, 8'h00);

    // 6: back-to-back writes with req held, zero wait states
    do_acc(1, 0, 16'h0100, 8'h11, 0, rd, e, lat, rc1);
    chk("b2b_lat", 8'(lat), 8'd1);
    do_acc(1, 0, 16'h0101, 8'h22, 0, rd, e, lat, rc2);
    chk("b2b_gap1", 8'(rc2 - rc1), 8'd2);
    do_acc(1, 0, 16'h0102, 8'h33, 1, rd, e, lat, rc);
    chk("b2b_gap2", 8'(rc - rc2), 8'd2);
    do_acc(1, 1, 16'h0100, 8'h00, 1, rd, e, lat, rc);
    chk("b2b_rd0", rd, 8'h11);
    do_acc(1, 1, 16'h0101, 8'h00, 1, rd, e, lat, rc);
    chk("b2b_rd1", rd, 8'h22);
    do_acc(1, 1, 16'h0102, 8'h00, 1, rd, e, lat, rc);
    chk("b2b_rd2", rd, 8'h33);

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
